// File: rtl/timer_alarm_scheduler.sv
// timer_alarm_scheduler: N_CH one-shot/periodic microsecond alarms served by one shared decrementer
// Ports: clk_200mhz/reset (sync, active-high); tick_us 1 us pulse; arm_valid/arm_ready/arm_delay/
// arm_periodic per-channel arm handshake; cancel disarms; armed/fire/status/overrun per-channel
// state, expiry pulse and sticky flags; status_clr clears status and overrun; tick_lost sticky.
module timer_alarm_scheduler #(
  parameter int N_CH = 4,
  parameter int DW = 24
) (
  input  logic               clk_200mhz,
  input  logic               reset,
  input  logic               tick_us,
  input  logic [N_CH-1:0]    arm_valid,
  output logic [N_CH-1:0]    arm_ready,
  input  logic [N_CH*DW-1:0] arm_delay,
  input  logic [N_CH-1:0]    arm_periodic,
  input  logic [N_CH-1:0]    cancel,
  output logic [N_CH-1:0]    armed,
  output logic [N_CH-1:0]    fire,
  output logic [N_CH-1:0]    status,
  input  logic [N_CH-1:0]    status_clr,
  output logic [N_CH-1:0]    overrun,
  output logic               tick_lost
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic tick_pending_q, tick_pending_d, tick_lost_q, tick_lost_d, last;
  logic [DW-1:0] count_q [N_CH];
  logic [DW-1:0] count_d [N_CH];
  logic [DW-1:0] period_q [N_CH];
  logic [DW-1:0] period_d [N_CH];
  logic [N_CH-1:0] armed_q, armed_d, periodic_q, periodic_d, skip_q, skip_d;
  logic [N_CH-1:0] fire_q, fire_d, status_q, status_d, overrun_q, overrun_d;
  assign last = idx_q == IW'(N_CH - 1);
  assign armed = armed_q;
  assign fire = fire_q;
  assign status = status_q;
  assign overrun = overrun_q;
  assign tick_lost = tick_lost_q;
  for (genvar g = 0; g < N_CH; g++) begin : g_rdy
    assign arm_ready[g] = ~(state_q == SWEEP && idx_q == IW'(g));
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    tick_pending_d = tick_pending_q;
    tick_lost_d = tick_lost_q | (tick_us & tick_pending_q);
    if (state_q == IDLE || last) begin
      state_d = (tick_us || tick_pending_q) ? SWEEP : IDLE;
      idx_d = '0;
      tick_pending_d = 1'b0;
    end else begin
      idx_d = idx_q + 1'b1;
      tick_pending_d = tick_pending_q | tick_us;
    end
  end
  // An arm accepted mid-sweep ahead of its slot sets skip, so the sweep that began
  // before the accept does not count toward the new delay.
  always_comb begin
    count_d = count_q;
    period_d = period_q;
    armed_d = armed_q;
    periodic_d = periodic_q;
    skip_d = skip_q;
    fire_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (state_q == SWEEP && idx_q == IW'(i)) begin
        if (skip_q[i]) skip_d[i] = 1'b0;
        else if (armed_q[i]) begin
          if (count_q[i] <= DW'(1)) begin
            fire_d[i] = ~cancel[i];
            count_d[i] = period_q[i];
            armed_d[i] = periodic_q[i];
          end else count_d[i] = count_q[i] - 1'b1;
        end
      end
      if (arm_valid[i] && arm_ready[i]) begin
        count_d[i] = arm_delay[i*DW +: DW] == '0 ? DW'(1) : arm_delay[i*DW +: DW];
        period_d[i] = arm_delay[i*DW +: DW] == '0 ? DW'(1) : arm_delay[i*DW +: DW];
        armed_d[i] = 1'b1;
        periodic_d[i] = arm_periodic[i];
        skip_d[i] = state_q == SWEEP && idx_q < IW'(i);
      end
      if (cancel[i]) armed_d[i] = 1'b0;
    end
  end
  always_comb begin
    status_d = fire_q | (status_q & ~status_clr);
    overrun_d = ~status_clr & (overrun_q | (fire_q & status_q));
  end
  always_ff @(posedge clk_200mhz) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      tick_pending_q <= 1'b0;
      tick_lost_q <= 1'b0;
      count_q <= '{default: '0};
      period_q <= '{default: '0};
      armed_q <= '0;
      periodic_q <= '0;
      skip_q <= '0;
      fire_q <= '0;
      status_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      tick_pending_q <= tick_pending_d;
      tick_lost_q <= tick_lost_d;
      count_q <= count_d;
      period_q <= period_d;
      armed_q <= armed_d;
      periodic_q <= periodic_d;
      skip_q <= skip_d;
      fire_q <= fire_d;
      status_q <= status_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// tb_timer_alarm_scheduler: directed scenarios plus random traffic checked against a tick-counting model
module tb_timer_alarm_scheduler;
  localparam int N = 4;
  localparam int DW = 24;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [N-1:0] av = '0, ap = '0, cn = '0, sc = '0;
  logic [N*DW-1:0] ad = '0;
  logic [N-1:0] arm_ready, armed, fire, status, overrun;
  logic tick_lost;
  int n_vec = 0, n_err = 0;
  int vis = -1;
  bit pend, lost;
  longint cyc_n = 0, start = 0;
  longint acc [N];
  int tgt [N];
  int seen [N];
  logic [N-1:0] m_arm = '0, m_per = '0, m_fire = '0, m_status = '0, m_over = '0;
  timer_alarm_scheduler #(.N_CH(N), .DW(DW)) dut (
    .clk_200mhz(clk), .reset(rst), .tick_us(tick), .arm_valid(av), .arm_ready(arm_ready),
    .arm_delay(ad), .arm_periodic(ap), .cancel(cn), .armed(armed), .fire(fire),
    .status(status), .status_clr(sc), .overrun(overrun), .tick_lost(tick_lost)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc_n, got, exp);
    end
  endtask
  task automatic step();
    logic [N-1:0] rdy, nf;
    int d;
    rdy = '1;
    if (vis >= 0) rdy[vis] = 1'b0;
    nf = '0;
    if (rst) begin
      vis = -1;
      pend = 0;
      lost = 0;
      m_arm = '0;
      m_per = '0;
      m_status = '0;
      m_over = '0;
      for (int i = 0; i < N; i++) begin
        seen[i] = 0;
        tgt[i] = 0;
        acc[i] = 0;
      end
    end else begin
      if (vis >= 0 && m_arm[vis] && start > acc[vis]) begin
        seen[vis]++;
        if (seen[vis] >= tgt[vis]) begin
          nf[vis] = ~cn[vis];
          seen[vis] = 0;
          m_arm[vis] = m_per[vis];
        end
      end
      for (int i = 0; i < N; i++) begin
        d = int'(ad[i*DW +: DW]);
        if (av[i] && rdy[i] && !cn[i]) begin
          m_arm[i] = 1'b1;
          m_per[i] = ap[i];
          tgt[i] = d == 0 ? 1 : d;
          seen[i] = 0;
          acc[i] = cyc_n;
        end
        if (cn[i]) m_arm[i] = 1'b0;
      end
      m_over = ~sc & (m_over | (m_fire & m_status));
      m_status = m_fire | (m_status & ~sc);
      lost = lost | (tick && pend);
      if (vis < 0 || vis == N - 1) begin
        if (tick || pend) begin
          vis = 0;
          start = cyc_n + 1;
        end else vis = -1;
        pend = 0;
      end else begin
        vis = vis + 1;
        pend = pend | tick;
      end
    end
    m_fire = nf;
    @(posedge clk);
    #1;
    cyc_n++;
    rdy = '1;
    if (vis >= 0) rdy[vis] = 1'b0;
    chk("fire", 64'(fire), 64'(m_fire));
    chk("armed", 64'(armed), 64'(m_arm));
    chk("status", 64'(status), 64'(m_status));
    chk("overrun", 64'(overrun), 64'(m_over));
    chk("tick_lost", 64'(tick_lost), 64'(lost));
    chk("arm_ready", 64'(arm_ready), 64'(rdy));
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask
  task automatic arm(input int ch, input int d, input bit per);
    av[ch] = 1'b1;
    ad[ch*DW +: DW] = DW'(d);
    ap[ch] = per;
    step();
    av[ch] = 1'b0;
  endtask
  initial begin
    idle(3);
    rst = 1'b0;
    chk("reset_ready", 64'(arm_ready), 64'hf);
    chk("reset_armed", 64'(armed), 64'h0);
    idle(2);
    arm(0, 3, 0);
    repeat (3) begin
      pulse_tick();
      idle(199);
    end
    chk("t1_status0", 64'(status[0]), 64'h1);
    chk("t1_armed0", 64'(armed[0]), 64'h0);
    arm(2, 2, 1);
    repeat (7) begin
      pulse_tick();
      idle(49);
    end
    chk("t2_overrun2", 64'(overrun[2]), 64'h1);
    sc = '1;
    step();
    sc = '0;
    cn[2] = 1'b1;
    step();
    cn[2] = 1'b0;
    av = '1;
    for (int i = 0; i < N; i++) ad[i*DW +: DW] = DW'(1);
    ap = '0;
    step();
    av = '0;
    pulse_tick();
    for (int i = 0; i < N; i++) begin
      step();
      chk("t3_fire_seq", 64'(fire), 64'(1 << i));
    end
    idle(20);
    pulse_tick();
    step();
    chk("t4_ready1", 64'(arm_ready[1]), 64'h0);
    av[1] = 1'b1;
    ad[1*DW +: DW] = DW'(2);
    step();
    step();
    av[1] = 1'b0;
    chk("t4_armed1", 64'(armed[1]), 64'h1);
    idle(20);
    arm(3, 5, 0);
    repeat (3) begin
      pulse_tick();
      idle(19);
    end
    tick = 1'b1;
    cn[3] = 1'b1;
    av[3] = 1'b1;
    step();
    tick = 1'b0;
    cn[3] = 1'b0;
    av[3] = 1'b0;
    idle(19);
    repeat (2) begin
      pulse_tick();
      idle(19);
    end
    chk("t6_armed3", 64'(armed[3]), 64'h0);
    pulse_tick();
    step();
    pulse_tick();
    pulse_tick();
    idle(12);
    chk("t5_tick_lost", 64'(tick_lost), 64'h1);
    arm(0, 1, 0);
    pulse_tick();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_fire", 64'(fire), 64'h0);
    chk("t6_rst_armed", 64'(armed), 64'h0);
    chk("t6_rst_lost", 64'(tick_lost), 64'h0);
    chk("t6_rst_ready", 64'(arm_ready), 64'hf);
    idle(3);
    for (int k = 0; k < 5000; k++) begin
      tick = $urandom_range(0, 9) == 0;
      for (int i = 0; i < N; i++) begin
        av[i] = $urandom_range(0, 39) == 0;
        ap[i] = 1'($urandom_range(0, 1));
        cn[i] = $urandom_range(0, 79) == 0;
        sc[i] = $urandom_range(0, 15) == 0;
        ad[i*DW +: DW] = DW'($urandom_range(0, 3));
      end
      rst = $urandom_range(0, 999) == 0;
      step();
    end
    rst = 1'b0;
    tick = 1'b0;
    av = '0;
    cn = '0;
    sc = '0;
    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
